ram_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the 1024x8 single-port synchronous RAM (cs/rd/wr control, tri-stated registered read data). It accepts independent read/write requests and serialises them into one RAM access at a time. It drives the RAM's cs, rd and wr with mutually exclusive rd/wr. It holds cs&&rd through the data-valid cycle, captures read data and returns it to the winning requester with a one-cycle ack.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/ram_arbiter_rr_arb2.sv | 23 ++
 rtl/ram_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Optional build macro RAM_ARB_STATS_EN is consumed by ram_arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_rec_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot winner from req, pointer favours the
// requester that was not served last and advances on every update strobe.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] win,
  output logic       ptr
);

  always_comb begin
    win = req;
    if (req == 2'b11) win = ptr ? 2'b10 : 2'b01;
  end

  // After requester 0 wins, requester 1 is favoured, and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ptr <= 1'b0;
    else if (upd && |win)  ptr <= win[0];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer serialising two requesters onto a 1024x8
// single-port synchronous RAM. Define RAM_ARB_STATS_EN for grant counters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [1:0]        dbg_state,
  output logic              dbg_ptr
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] gnt_cnt0,
  output logic [STAT_W-1:0] gnt_cnt1
`endif
);

  // Handshake: reqN is a level held until gntN; gntN (ACCESS cycle) means the
  // request is latched, ackN (DONE cycle) means the access is complete.

  state_t     state_q, state_d;
  req_rec_t   rec_q;
  logic       id_q;
  logic [1:0] win;
  logic       take;

  assign take = (state_q == IDLE) && (req0 || req1);

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1, req0}),
    .upd   (take),
    .win   (win),
    .ptr   (dbg_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rec_q   <= '0;
      id_q    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        id_q  <= win[1];
        rec_q <= win[1] ? '{we: we1, addr: addr1, wdata: wdata1}
                        : '{we: we0, addr: addr0, wdata: wdata0};
      end
      // RAM output is driven and valid throughout HOLD; capture at its end.
      if (state_q == HOLD) begin
        if (id_q) rdata1 <= ram_rdata;
        else      rdata0 <= ram_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    ram_cs  = 1'b0;
    ram_rd  = 1'b0;
    ram_wr  = 1'b0;
    case (state_q)
      IDLE: if (req0 || req1) state_d = ACCESS;
      ACCESS: begin
        gnt0    = !id_q;
        gnt1    = id_q;
        ram_cs  = 1'b1;
        ram_wr  = rec_q.we;
        ram_rd  = !rec_q.we;
        state_d = rec_q.we ? DONE : HOLD;
      end
      HOLD: begin
        ram_cs  = 1'b1;
        ram_rd  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        ack0    = !id_q;
        ack1    = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign ram_addr  = rec_q.addr;
  assign ram_wdata = rec_q.wdata;
  assign dbg_state = state_q;

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (gnt1 && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule
